doppler_button_debounce: RTL and testbench

Per-button synchronizer, debouncer and event generator for the Doppler board push-buttons. It sits between the pad-level SB_IO inputs (active-low, pull-up enabled) and the memory-mapped button data register. It delivers clean active-high levels plus single-cycle press, release and long-press strobes, so bus software never sees contact bounce or metastable samples.

---
 rtl/doppler_button_debounce.sv | 209 ++++++++++++++++++++
 tb/tb_doppler_button_debounce.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/doppler_button_debounce.sv
// ============================================================================
// doppler_button_debounce
//
// Purpose:
//   Turns the raw, active-low Doppler board push-button pads into clean,
//   active-high button levels. Each channel also produces single-cycle press,
//   release and long-press strobes for the memory-mapped button register.
//   Every channel is independent. Each one has a two-flop synchronizer, a
//   four-state debounce FSM and one counter. The counter times both the
//   debounce window and the long-press interval.
//
// Parameters:
//   NUM_BUTTONS      number of independent button channels
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept a change (>= 2)
//   LONG_CYCLES      cycles of continuous debounced press before btn_long
//                    (> DEBOUNCE_CYCLES)
//
// Ports:
//   clk           system clock; all flops are rising-edge
//   reset         synchronous, active-high reset
//   btn_raw_n     raw pad levels, 0 = pressed, asynchronous to clk
//   btn_state     debounced level, 1 = pressed
//   btn_pressed   one-cycle strobe on an accepted press
//   btn_released  one-cycle strobe on an accepted release
//   btn_long      one-cycle strobe, at most once per press, after LONG_CYCLES
// ============================================================================
module doppler_button_debounce #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw_n,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic [NUM_BUTTONS-1:0] btn_pressed,
    output logic [NUM_BUTTONS-1:0] btn_released,
    output logic [NUM_BUTTONS-1:0] btn_long
);

    // The counter only needs to reach LONG_CYCLES. It saturates there and never wraps.
    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_ZERO  = cnt_t'(0);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t DEB_FULL  = cnt_t'(DEBOUNCE_CYCLES);
    localparam cnt_t LONG_LAST = cnt_t'(LONG_CYCLES - 1);
    localparam cnt_t LONG_FULL = cnt_t'(LONG_CYCLES);

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_PEND,
        ST_PRESSED,
        ST_RELEASE_PEND
    } state_e;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan

        logic   s0_q;
        logic   s1_q;
        state_e state_q;
        state_e state_d;
        cnt_t   cnt_q;
        cnt_t   cnt_d;
        logic   long_done_q;
        logic   long_done_d;
        logic   level_q;
        logic   level_d;
        logic   pressed_q;
        logic   pressed_d;
        logic   released_q;
        logic   released_d;
        logic   long_q;
        logic   long_d;

        // State register. It holds the synchronizer, FSM, counter, long-press
        // flag and all registered outputs. The synchronizer inverts the pad
        // level, so everything after s0 is active-high. Reset returns the
        // channel to "released" and does not emit a release strobe. A button
        // held through reset therefore shows up again as a fresh press.
        always_ff @(posedge clk) begin
            if (reset) begin
                s0_q        <= 1'b0;
                s1_q        <= 1'b0;
                state_q     <= ST_RELEASED;
                cnt_q       <= CNT_ZERO;
                long_done_q <= 1'b0;
                level_q     <= 1'b0;
                pressed_q   <= 1'b0;
                released_q  <= 1'b0;
                long_q      <= 1'b0;
            end else begin
                s0_q        <= ~btn_raw_n[i];
                s1_q        <= s0_q;
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                long_done_q <= long_done_d;
                level_q     <= level_d;
                pressed_q   <= pressed_d;
                released_q  <= released_d;
                long_q      <= long_d;
            end
        end

        // Next-state logic. A pending state survives only while the
        // synchronized sample keeps agreeing with the new level, so bounce
        // shorter than the debounce window falls back silently. After the
        // press is accepted, the counter continues from DEBOUNCE_CYCLES.
        // That puts btn_long LONG_CYCLES after the first stable sample.
        // A short release glitch restarts the long-press count. The exception
        // is when the long strobe already fired: then the counter jumps
        // straight to saturation.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            long_done_d = long_done_q;
            unique case (state_q)
                ST_RELEASED: begin
                    if (s1_q) begin
                        state_d = ST_PRESS_PEND;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_PRESS_PEND: begin
                    if (!s1_q) begin
                        state_d = ST_RELEASED;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = DEB_FULL;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!s1_q) begin
                        state_d = ST_RELEASE_PEND;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == LONG_LAST) begin
                        cnt_d       = LONG_FULL;
                        long_done_d = 1'b1;
                    end else if (cnt_q < LONG_FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (s1_q) begin
                        state_d = ST_PRESSED;
                        cnt_d   = long_done_q ? LONG_FULL : DEB_FULL;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d     = ST_RELEASED;
                        cnt_d       = CNT_ZERO;
                        long_done_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        // Output logic. It computes the next value of each registered output
        // from the current state and the synchronized sample only, never from
        // the raw pad. The three strobes come from mutually exclusive
        // transitions, so at most one of them is high in any cycle.
        always_comb begin
            level_d    = level_q;
            pressed_d  = 1'b0;
            released_d = 1'b0;
            long_d     = 1'b0;
            unique case (state_q)
                ST_PRESS_PEND: begin
                    if (s1_q && (cnt_q == DEB_LAST)) begin
                        level_d   = 1'b1;
                        pressed_d = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (s1_q && (cnt_q == LONG_LAST) && !long_done_q) begin
                        long_d = 1'b1;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (!s1_q && (cnt_q == DEB_LAST)) begin
                        level_d    = 1'b0;
                        released_d = 1'b1;
                    end
                end
                default: begin
                    level_d = level_q;
                end
            endcase
        end

        assign btn_state[i]    = level_q;
        assign btn_pressed[i]  = pressed_q;
        assign btn_released[i] = released_q;
        assign btn_long[i]     = long_q;
    end

endmodule

// File: tb/tb_doppler_button_debounce.sv
// Bench for doppler_button_debounce with DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
// The stimulus drives pads on the falling edge. Every strobe it expects is
// queued with the count of rising edges after which the strobe must be
// visible. A separate monitor pops the queue whenever any strobe is high.
module tb_doppler_button_debounce;

    localparam int NB   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    typedef struct packed {
        logic [1:0]  pr;
        logic [1:0]  rl;
        logic [1:0]  lg;
        logic [31:0] cyc;
    } event_t;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btnRawN;
    logic [NB-1:0] btnState;
    logic [NB-1:0] btnPressed;
    logic [NB-1:0] btnReleased;
    logic [NB-1:0] btnLong;

    int     compared;
    int     mismatched;
    int     edgeCount;
    logic   monitorEn;
    event_t expQ[$];

    doppler_button_debounce #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_raw_n    (btnRawN),
        .btn_state    (btnState),
        .btn_pressed  (btnPressed),
        .btn_released (btnReleased),
        .btn_long     (btnLong)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so expected strobe times can be written as offsets.
    initial edgeCount = 0;
    always @(posedge clk) edgeCount = edgeCount + 1;

    // Hard stop in case the run wanders off.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard monitor. On every falling edge it first retires any expected
    // event whose cycle has passed without a strobe. When any strobe is high,
    // it then compares the strobe vectors and the edge count with the head
    // of the queue.
    always @(negedge clk) begin
        event_t e;
        if (monitorEn) begin
            if (expQ.size() != 0 && expQ[0].cyc < edgeCount) begin
                e = expQ.pop_front();
                compared++;
                mismatched++;
                $display("[TB] FAIL missed_event: actual=none at edge %0d required pr=%b rl=%b lg=%b at edge %0d",
                         edgeCount, e.pr, e.rl, e.lg, e.cyc);
            end
            if (|btnPressed || |btnReleased || |btnLong) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_strobe: actual pr=%b rl=%b lg=%b at edge %0d required=no strobe",
                             btnPressed, btnReleased, btnLong, edgeCount);
                end else begin
                    e = expQ.pop_front();
                    if (e.pr !== btnPressed || e.rl !== btnReleased || e.lg !== btnLong || e.cyc != edgeCount) begin
                        mismatched++;
                        $display("[TB] FAIL strobe: actual pr=%b rl=%b lg=%b at edge %0d required pr=%b rl=%b lg=%b at edge %0d",
                                 btnPressed, btnReleased, btnLong, edgeCount, e.pr, e.rl, e.lg, e.cyc);
                    end
                end
            end
        end
    end

    // Compare the debounced level with the hand-computed value.
    task automatic checkOutput(input string name, input logic [NB-1:0] expState);
        compared++;
        if (btnState !== expState) begin
            mismatched++;
            $display("[TB] FAIL %s: actual btn_state=%b required=%b at edge %0d", name, btnState, expState, edgeCount);
        end
    endtask

    // Drive the pads and reset on the current falling edge.
    task automatic applyStimulus(input logic [NB-1:0] raw, input logic rst);
        btnRawN = raw;
        reset   = rst;
    endtask

    // Move forward falling edge by falling edge until the edge count reaches target.
    task automatic waitUntil(input int target);
        while (edgeCount < target) @(negedge clk);
    endtask

    task automatic pushEvent(input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] lg, input int cyc);
        event_t e;
        e.pr  = pr;
        e.rl  = rl;
        e.lg  = lg;
        e.cyc = 32'(cyc);
        expQ.push_back(e);
    endtask

    // Directed stimulus sequence.
    initial begin
        int n;
        monitorEn = 1'b0;
        compared   = 0;
        mismatched = 0;
        applyStimulus(2'b11, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        applyStimulus(2'b11, 1'b0);
        monitorEn = 1'b1;
        checkOutput("reset_state", 2'b00);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checkOutput("idle_state", 2'b00);
        end

        // Clean press, then release, of button 0.
        applyStimulus(2'b10, 1'b0);
        n = edgeCount;
        pushEvent(2'b01, 2'b00, 2'b00, n + 6);
        waitUntil(n + 5);
        checkOutput("press_not_yet", 2'b00);
        waitUntil(n + 6);
        checkOutput("press_level", 2'b01);
        applyStimulus(2'b11, 1'b0);
        n = edgeCount;
        pushEvent(2'b00, 2'b01, 2'b00, n + 6);
        waitUntil(n + 5);
        checkOutput("release_not_yet", 2'b01);
        waitUntil(n + 6);
        checkOutput("release_level", 2'b00);

        // Bounce: 0,0,0,1 repeated ten times must be rejected.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus((k == 3) ? 2'b11 : 2'b10, 1'b0);
                @(negedge clk);
            end
        end
        checkOutput("bounce_level", 2'b00);

        // Hold: one press, then one long strobe 16 cycles later.
        applyStimulus(2'b10, 1'b0);
        n = edgeCount;
        pushEvent(2'b01, 2'b00, 2'b00, n + 6);
        pushEvent(2'b00, 2'b00, 2'b01, n + 22);
        waitUntil(n + 6);
        checkOutput("hold_press_level", 2'b01);
        waitUntil(n + 22 + 100);
        checkOutput("long_hold_level", 2'b01);

        // Two-cycle release glitch after the long strobe.
        applyStimulus(2'b11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(2'b10, 1'b0);
        n = edgeCount;
        waitUntil(n + 40);
        checkOutput("glitch_level", 2'b01);

        // Release after the long press.
        applyStimulus(2'b11, 1'b0);
        n = edgeCount;
        pushEvent(2'b00, 2'b01, 2'b00, n + 6);
        waitUntil(n + 6);
        checkOutput("long_release_level", 2'b00);
        waitUntil(n + 10);

        // Press both buttons on the same edge, then reset while they are held.
        applyStimulus(2'b00, 1'b0);
        n = edgeCount;
        pushEvent(2'b11, 2'b00, 2'b00, n + 6);
        waitUntil(n + 8);
        checkOutput("dual_press_level", 2'b11);
        applyStimulus(2'b00, 1'b1);
        @(negedge clk);
        checkOutput("mid_reset_level", 2'b00);
        @(negedge clk);
        applyStimulus(2'b00, 1'b0);
        n = edgeCount;
        pushEvent(2'b11, 2'b00, 2'b00, n + 6);
        waitUntil(n + 5);
        checkOutput("repress_not_yet", 2'b00);
        waitUntil(n + 6);
        checkOutput("repress_level", 2'b11);

        // Release both together.
        applyStimulus(2'b11, 1'b0);
        n = edgeCount;
        pushEvent(2'b00, 2'b11, 2'b00, n + 6);
        waitUntil(n + 6);
        checkOutput("dual_release_level", 2'b00);
        waitUntil(n + 12);

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drained: actual=%0d pending required=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
